y86_regfile: RTL and testbench

Y86-64 sequential-processor register file with its decode-side read logic and writeback-side write logic. Decode derives srcA/srcB from icode/rA/rB and drives valA/valB combinationally. Writeback derives dstE/dstM from icode/cond/rA/rB and commits valE/valM on the rising clock edge. It sits between fetch (icode, rA, rB) and execute/memory (valE, valM, cond), with a sticky halt state that freezes architectural state.

---
 rtl/y86_regfile_pkg.sv | 30 +++
 rtl/y86_reg_select.sv | 63 ++++++
 rtl/y86_regfile.sv | 125 ++++++++++++
 tb/tb_y86_regfile.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_regfile_pkg.sv
// Shared Y86-64 constants: instruction codes, special register IDs and halt FSM states.
package y86_regfile_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] REG_RSP  = 4'h4;
  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } halt_state_e;

  // Codes above POPQ are undefined and must never touch architectural state.
  function automatic logic icode_valid(input logic [3:0] ic);
    return ic <= I_POPQ;
  endfunction

endpackage

// File: rtl/y86_reg_select.sv
// Combinational source/destination register-ID derivation for decode and writeback.
module y86_reg_select
  import y86_regfile_pkg::*;
(
  input  logic [3:0] i_icode,
  input  logic       i_cond,
  input  logic [3:0] i_ra,
  input  logic [3:0] i_rb,
  output logic [3:0] o_src_a,
  output logic [3:0] o_src_b,
  output logic [3:0] o_dst_e,
  output logic [3:0] o_dst_m
);

  always_comb begin
    o_src_a = REG_NONE;
    o_src_b = REG_NONE;
    o_dst_e = REG_NONE;
    o_dst_m = REG_NONE;
    case (i_icode)
      I_RRMOVQ: begin
        o_src_a = i_ra;
        o_dst_e = i_cond ? i_rb : REG_NONE;
      end
      I_IRMOVQ: o_dst_e = i_rb;
      I_RMMOVQ: begin
        o_src_a = i_ra;
        o_src_b = i_rb;
      end
      I_MRMOVQ: begin
        o_src_b = i_rb;
        o_dst_m = i_ra;
      end
      I_OPQ: begin
        o_src_a = i_ra;
        o_src_b = i_rb;
        o_dst_e = i_rb;
      end
      I_CALL: begin
        o_src_b = REG_RSP;
        o_dst_e = REG_RSP;
      end
      I_RET: begin
        o_src_a = REG_RSP;
        o_src_b = REG_RSP;
        o_dst_e = REG_RSP;
      end
      I_PUSHQ: begin
        o_src_a = i_ra;
        o_src_b = REG_RSP;
        o_dst_e = REG_RSP;
      end
      I_POPQ: begin
        o_src_a = REG_RSP;
        o_src_b = REG_RSP;
        o_dst_e = REG_RSP;
        o_dst_m = i_ra;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/y86_regfile.sv
// Y86-64 register file: combinational decode reads, edge-triggered writeback, sticky halt.
module y86_regfile
  import y86_regfile_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int NREG  = 15   // at most 15: ID 0xF is reserved for "none"
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              icode,
  input  logic                    cond,
  input  logic [3:0]              rA,
  input  logic [3:0]              rB,
  input  logic [WIDTH-1:0]        valE,
  input  logic [WIDTH-1:0]        valM,
  input  logic                    wb_en,
  input  logic                    hlt,
  output logic signed [WIDTH-1:0] valA,
  output logic signed [WIDTH-1:0] valB,
  output logic                    halted,
  output logic [WIDTH-1:0]        r0,
  output logic [WIDTH-1:0]        r1,
  output logic [WIDTH-1:0]        r2,
  output logic [WIDTH-1:0]        r3,
  output logic [WIDTH-1:0]        r4,
  output logic [WIDTH-1:0]        r5,
  output logic [WIDTH-1:0]        r6,
  output logic [WIDTH-1:0]        r7,
  output logic [WIDTH-1:0]        r8,
  output logic [WIDTH-1:0]        r9,
  output logic [WIDTH-1:0]        r10,
  output logic [WIDTH-1:0]        r11,
  output logic [WIDTH-1:0]        r12,
  output logic [WIDTH-1:0]        r13,
  output logic [WIDTH-1:0]        r14
);

  logic [WIDTH-1:0] r_regs [NREG];
  halt_state_e      r_state;
  halt_state_e      w_state_next;

  logic [3:0]       w_src_a;
  logic [3:0]       w_src_b;
  logic [3:0]       w_dst_e;
  logic [3:0]       w_dst_m;
  logic             w_commit;
  logic [WIDTH-1:0] w_val_a;
  logic [WIDTH-1:0] w_val_b;
  logic [WIDTH-1:0] w_tap [15];

  y86_reg_select u_sel (
    .i_icode (icode),
    .i_cond  (cond),
    .i_ra    (rA),
    .i_rb    (rB),
    .o_src_a (w_src_a),
    .o_src_b (w_src_b),
    .o_dst_e (w_dst_e),
    .o_dst_m (w_dst_m)
  );

  // A halt instruction selects no destinations, so committing in the same edge
  // that enters HALT is harmless and the last real instruction always lands.
  assign w_commit = wb_en && (r_state == ST_RUN) && icode_valid(icode);

  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_RUN && (hlt || (wb_en && icode == I_HALT)))
      w_state_next = ST_HALT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_next;
  end

  assign halted = (r_state == ST_HALT);

  // dstM is checked first so that popq %rsp keeps the popped value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    end else if (w_commit) begin
      for (int k = 0; k < NREG; k++) begin
        if (w_dst_m == 4'(k))      r_regs[k] <= valM;
        else if (w_dst_e == 4'(k)) r_regs[k] <= valE;
      end
    end
  end

  // IDs with no backing register (0xF or >= NREG) match nothing and read zero.
  always_comb begin
    w_val_a = '0;
    w_val_b = '0;
    for (int k = 0; k < NREG; k++) begin
      if (w_src_a == 4'(k)) w_val_a = r_regs[k];
      if (w_src_b == 4'(k)) w_val_b = r_regs[k];
    end
  end

  assign valA = w_val_a;
  assign valB = w_val_b;

  always_comb begin
    for (int j = 0; j < 15; j++) w_tap[j] = '0;
    for (int k = 0; k < NREG; k++) w_tap[k] = r_regs[k];
  end

  assign r0  = w_tap[0];
  assign r1  = w_tap[1];
  assign r2  = w_tap[2];
  assign r3  = w_tap[3];
  assign r4  = w_tap[4];
  assign r5  = w_tap[5];
  assign r6  = w_tap[6];
  assign r7  = w_tap[7];
  assign r8  = w_tap[8];
  assign r9  = w_tap[9];
  assign r10 = w_tap[10];
  assign r11 = w_tap[11];
  assign r12 = w_tap[12];
  assign r13 = w_tap[13];
  assign r14 = w_tap[14];

endmodule

// File: tb/tb_y86_regfile.sv
// Directed bench for y86_regfile with a queued scoreboard checked by a negedge monitor.
module tb_y86_regfile;
  localparam int W = 64;

  localparam int SEL_VALA   = 15;
  localparam int SEL_VALB   = 16;
  localparam int SEL_HALTED = 17;

  // Inputs change at posedge+2; the monitor samples at negedge, the commit edge is the next posedge.
  logic         clk;
  logic         rst_n;
  logic [3:0]   icode;
  logic         cond;
  logic [3:0]   rA;
  logic [3:0]   rB;
  logic [W-1:0] valE;
  logic [W-1:0] valM;
  logic         wb_en;
  logic         hlt;
  logic signed [W-1:0] valA;
  logic signed [W-1:0] valB;
  logic         halted;
  logic [W-1:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14;

  y86_regfile #(.WIDTH(W), .NREG(15)) dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .cond(cond), .rA(rA), .rB(rB),
    .valE(valE), .valM(valM), .wb_en(wb_en), .hlt(hlt),
    .valA(valA), .valB(valB), .halted(halted),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           sel_q[$];
  string        name_q[$];
  int           req_cnt  = 0;
  int           done_cnt = 0;
  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_timeout = 0;

  function automatic logic [W-1:0] observe(input int sel);
    case (sel)
      0: return r0;   1: return r1;   2: return r2;   3: return r3;
      4: return r4;   5: return r5;   6: return r6;   7: return r7;
      8: return r8;   9: return r9;   10: return r10; 11: return r11;
      12: return r12; 13: return r13; 14: return r14;
      SEL_VALA:   return valA;
      SEL_VALB:   return valB;
      SEL_HALTED: return {{(W-1){1'b0}}, halted};
      default:    return '0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (done_cnt != req_cnt) begin
      while (exp_q.size() > 0) begin
        logic [W-1:0] e;
        logic [W-1:0] got;
        int           s;
        string        nm;
        e   = exp_q.pop_front();
        s   = sel_q.pop_front();
        nm  = name_q.pop_front();
        got = observe(s);
        n_checks++;
        if (got !== e) begin
          n_fail++;
          $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, e);
        end
      end
      done_cnt = req_cnt;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic expect_val(input string nm, input int sel, input logic [W-1:0] e);
    name_q.push_back(nm);
    sel_q.push_back(sel);
    exp_q.push_back(e);
  endtask

  task automatic expect_regs(input string nm, input logic [W-1:0] e [15]);
    for (int i = 0; i < 15; i++) expect_val($sformatf("%s_r%0d", nm, i), i, e[i]);
  endtask

  task automatic check_now(input string nm);
    int waited;
    req_cnt++;
    waited = 0;
    while (done_cnt != req_cnt && waited < 4) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (done_cnt != req_cnt) begin
      n_fail++;
      n_timeout++;
      $display("FAIL %s_timeout: monitor did not respond, got %0d pending expected 0", nm, exp_q.size());
      exp_q.delete();
      sel_q.delete();
      name_q.delete();
      done_cnt = req_cnt;
    end
  endtask

  // Holds the new inputs across exactly one rising edge before the next issue.
  task automatic issue(input logic [3:0] ic, input logic c, input logic [3:0] a,
                       input logic [3:0] b, input logic [W-1:0] e, input logic [W-1:0] m,
                       input logic wb, input logic h);
    @(posedge clk);
    #2;
    icode = ic; cond = c; rA = a; rB = b; valE = e; valM = m; wb_en = wb; hlt = h;
  endtask

  task automatic idle();
    issue(4'h1, 1'b0, 4'hF, 4'hF, '0, '0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] m [15];

  initial begin
    rst_n = 1'b0;
    icode = 4'h1; cond = 1'b0; rA = 4'hF; rB = 4'hF; valE = '0; valM = '0;
    wb_en = 1'b0; hlt = 1'b0;
    for (int i = 0; i < 15; i++) m[i] = '0;

    repeat (2) @(posedge clk);
    #2;
    expect_regs("reset", m);
    expect_val("reset_halted", SEL_HALTED, 0);
    expect_val("reset_valA", SEL_VALA, 0);
    expect_val("reset_valB", SEL_VALB, 0);
    check_now("reset");
    rst_n = 1'b1;

    // irmovq $10, %r2
    issue(4'h3, 1'b0, 4'hF, 4'h2, 64'd10, 64'd0, 1'b1, 1'b0);
    idle();
    m[2] = 64'd10;
    expect_regs("irmovq", m);
    check_now("irmovq");

    // irmovq $5, %r3 then addq %r2, %r3
    issue(4'h3, 1'b0, 4'hF, 4'h3, 64'd5, 64'd0, 1'b1, 1'b0);
    issue(4'h6, 1'b0, 4'h2, 4'h3, 64'd15, 64'd0, 1'b1, 1'b0);
    expect_val("opq_valA", SEL_VALA, 64'd10);
    expect_val("opq_valB", SEL_VALB, 64'd5);
    expect_val("opq_r3_before_commit", 3, 64'd5);
    check_now("opq_read");
    idle();
    m[3] = 64'd15;
    expect_val("opq_r3", 3, 64'd15);
    expect_val("opq_r2", 2, 64'd10);
    check_now("opq_commit");

    // cmovXX not taken, then taken
    issue(4'h2, 1'b0, 4'h2, 4'h5, 64'd7, 64'd0, 1'b1, 1'b0);
    expect_val("cmov_valA", SEL_VALA, 64'd10);
    check_now("cmov_read");
    idle();
    expect_val("cmov_nt_r5", 5, 64'd0);
    check_now("cmov_nt");
    issue(4'h2, 1'b1, 4'h2, 4'h5, 64'd7, 64'd0, 1'b1, 1'b0);
    idle();
    m[5] = 64'd7;
    expect_val("cmov_t_r5", 5, 64'd7);
    check_now("cmov_t");

    // popq %rsp: dstE == dstM == 4, memory value wins
    issue(4'h3, 1'b0, 4'hF, 4'h4, 64'h100, 64'd0, 1'b1, 1'b0);
    issue(4'hB, 1'b0, 4'h4, 4'hF, 64'h108, 64'h55, 1'b1, 1'b0);
    expect_val("popq_valA", SEL_VALA, 64'h100);
    expect_val("popq_valB", SEL_VALB, 64'h100);
    check_now("popq_read");
    idle();
    m[4] = 64'h55;
    expect_val("popq_r4", 4, 64'h55);
    check_now("popq_commit");

    // pushq %r3: valA = r3, valB = rsp, rsp <- valE
    issue(4'hA, 1'b0, 4'h3, 4'hF, 64'h4D, 64'd0, 1'b1, 1'b0);
    expect_val("pushq_valA", SEL_VALA, 64'd15);
    expect_val("pushq_valB", SEL_VALB, 64'h55);
    check_now("pushq_read");
    idle();
    m[4] = 64'h4D;
    expect_val("pushq_r4", 4, 64'h4D);
    check_now("pushq_commit");

    // mrmovq 0(%r3), %r6
    issue(4'h5, 1'b0, 4'h6, 4'h3, 64'h999, 64'h77, 1'b1, 1'b0);
    expect_val("mrmovq_valB", SEL_VALB, 64'd15);
    check_now("mrmovq_read");
    idle();
    m[6] = 64'h77;
    expect_regs("mrmovq", m);
    check_now("mrmovq_commit");

    // rA = 0xF reads zero; invalid icode commits nothing and does not halt
    issue(4'h2, 1'b0, 4'hF, 4'h5, 64'd0, 64'd0, 1'b0, 1'b0);
    expect_val("none_valA", SEL_VALA, 64'd0);
    check_now("none_read");
    issue(4'hC, 1'b1, 4'h2, 4'h2, 64'd99, 64'd98, 1'b1, 1'b0);
    expect_val("invalid_valA", SEL_VALA, 64'd0);
    expect_val("invalid_valB", SEL_VALB, 64'd0);
    check_now("invalid_read");
    idle();
    expect_regs("invalid", m);
    expect_val("invalid_halted", SEL_HALTED, 0);
    check_now("invalid_commit");

    // hlt edge, then a write attempt is frozen out
    issue(4'h1, 1'b0, 4'hF, 4'hF, '0, '0, 1'b0, 1'b1);
    issue(4'h3, 1'b0, 4'hF, 4'h1, 64'd9, 64'd0, 1'b1, 1'b0);
    idle();
    expect_val("halt_halted", SEL_HALTED, 1);
    expect_val("halt_r1", 1, 64'd0);
    expect_val("halt_r2", 2, 64'd10);
    check_now("halt");

    // async reset mid-cycle with a write pending
    issue(4'h3, 1'b0, 4'hF, 4'h8, 64'd33, 64'd0, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    for (int i = 0; i < 15; i++) m[i] = '0;
    expect_regs("rst2", m);
    expect_val("rst2_halted", SEL_HALTED, 0);
    check_now("rst2");
    @(posedge clk);
    #1;
    expect_val("rst2_held_r8", 8, 64'd0);
    check_now("rst2_held");
    rst_n = 1'b1;

    // last instruction commits, then halt instruction freezes state
    issue(4'h3, 1'b0, 4'hF, 4'h7, 64'd3, 64'd0, 1'b1, 1'b0);
    issue(4'h0, 1'b0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b1, 1'b0);
    issue(4'h3, 1'b0, 4'hF, 4'h7, 64'd8, 64'd0, 1'b1, 1'b0);
    idle();
    expect_val("ihalt_halted", SEL_HALTED, 1);
    expect_val("ihalt_r7", 7, 64'd3);
    check_now("ihalt");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks + n_timeout, n_fail);
    $finish;
  end

endmodule
